// File: rtl/frame_base_scheduler.sv
// frame_base_scheduler
//   Steps the SDRAM read base address one frame per VGA frame boundary so that
//   the display walks through a ring of stored frames. The ring size is
//   recomputed (frame size x frame count) whenever the pixel mode or the frame
//   count changes.
//
//   Build option: define FRAME_SCHED_MUTE_EN to register BLANK on every VSYNC
//   rise as NOT SYNC_EN. Without it BLANK is tied low and has no flop.
//
//   Ports
//     CLK, RESET        clock, async active-high reset
//     VSYNC             VGA vertical sync, asynchronous to CLK
//     SYNC_EN           camera enable (low = soft clear), asynchronous
//     ADVANCE           step request, sampled at frame boundaries
//     PIXEL_MODE[1:0]   01 1-bit, 10 8-bit, 11 16-bit, 00 single frame
//     FRAME_NO[7:0]     number of stored frames (0 treated as 1)
//     BASE_ADDR         read base address
//     RD_MAX_ADDR       BASE_ADDR + frame size
//     MAX_ADDR          ring end (frame size x frame count)
//     FRAME_IDX         index of the current frame
//     READY             ring size valid (high in RUN)
//     SYNC_OUT          synchronized VSYNC, gated until priming completes
//     BASE_VALID        BASE_ADDR nonzero or enable high
//     BLANK             mute flag (see build option)
//
//   state | meaning
//   IDLE  | just out of reset, one cycle
//   CALC  | 8-cycle shift-add of frame size x frame count
//   RUN   | ring size valid, base steps on frame boundaries
module frame_base_scheduler #(
   parameter int FRAME_WORDS  = 307200,
   parameter int ADDR_W       = 27,
   parameter int PRIME_FRAMES = 3
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              VSYNC,
   input  logic              SYNC_EN,
   input  logic              ADVANCE,
   input  logic [1:0]        PIXEL_MODE,
   input  logic [7:0]        FRAME_NO,
   output logic [ADDR_W-1:0] BASE_ADDR,
   output logic [ADDR_W-1:0] RD_MAX_ADDR,
   output logic [ADDR_W-1:0] MAX_ADDR,
   output logic [7:0]        FRAME_IDX,
   output logic              READY,
   output logic              SYNC_OUT,
   output logic              BASE_VALID,
   output logic              BLANK
);

   localparam logic [ADDR_W-1:0] FS_1BIT = ADDR_W'(38400);
   localparam logic [ADDR_W-1:0] FS_FULL = ADDR_W'(FRAME_WORDS);
   localparam logic [7:0]        PRIME   = 8'(PRIME_FRAMES);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_RUN} state_t;

   state_t            state_q, state_d;
   logic [2:0]        calc_cnt_q, calc_cnt_d;
   logic [ADDR_W-1:0] acc_q, acc_d;
   logic [ADDR_W-1:0] fs_q, fs_d;
   logic [7:0]        n_q, n_d;
   logic [1:0]        pm_q, pm_d;
   logic [7:0]        fno_q, fno_d;
   logic [ADDR_W-1:0] max_q, max_d;
   logic              ready_q, ready_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] rd_max_q;
   logic [7:0]        idx_q, idx_d;
   logic [7:0]        prime_q, prime_d;
   logic              gate_q, gate_d;
   logic              sync_out_q, base_valid_q;
   logic              vs_meta_q, vs_sync_q, vs_prev_q;
   logic              en_meta_q, en_sync_q;

   logic              fb;
   logic [ADDR_W-1:0] fs_sel, step_sum, adv_sum;
   logic [7:0]        n_sel, prime_dec;
   logic              cfg_changed;

   assign fb          = vs_prev_q & ~vs_sync_q;
   assign fs_sel      = (PIXEL_MODE == 2'b01) ? FS_1BIT : FS_FULL;
   assign n_sel       = (PIXEL_MODE == 2'b00 || FRAME_NO == 8'd0) ? 8'd1 : FRAME_NO;
   assign cfg_changed = (PIXEL_MODE != pm_q) || (FRAME_NO != fno_q);
   // MSB-first multiply: the down-counter doubles as the multiplier bit index
   assign step_sum    = {acc_q[ADDR_W-2:0], 1'b0} + (n_q[calc_cnt_q] ? fs_q : '0);
   assign adv_sum     = base_q + fs_q;
   assign prime_dec   = (prime_q == 8'd0) ? 8'd0 : prime_q - 8'd1;

   always_comb begin
      state_d    = state_q;
      calc_cnt_d = calc_cnt_q;
      acc_d      = acc_q;
      fs_d       = fs_q;
      n_d        = n_q;
      pm_d       = pm_q;
      fno_d      = fno_q;
      max_d      = max_q;
      ready_d    = ready_q;
      base_d     = base_q;
      idx_d      = idx_q;
      prime_d    = prime_q;
      gate_d     = gate_q;

      case (state_q)
         S_IDLE: begin
            state_d    = S_CALC;
            ready_d    = 1'b0;
            pm_d       = PIXEL_MODE;
            fno_d      = FRAME_NO;
            fs_d       = fs_sel;
            n_d        = n_sel;
            acc_d      = '0;
            calc_cnt_d = 3'd7;
         end
         S_CALC: begin
            acc_d = step_sum;
            if (calc_cnt_q == 3'd0) begin
               state_d = S_RUN;
               max_d   = step_sum;
               ready_d = 1'b1;
               if (base_q >= step_sum) begin
                  base_d = '0;
                  idx_d  = 8'd0;
               end
            end else begin
               calc_cnt_d = calc_cnt_q - 3'd1;
            end
         end
         S_RUN: begin
            if (cfg_changed) begin
               state_d    = S_CALC;
               ready_d    = 1'b0;
               pm_d       = PIXEL_MODE;
               fno_d      = FRAME_NO;
               fs_d       = fs_sel;
               n_d        = n_sel;
               acc_d      = '0;
               calc_cnt_d = 3'd7;
            end else if (fb) begin
               if (ADVANCE) begin
                  if (adv_sum < max_q) begin
                     base_d = adv_sum;
                     idx_d  = idx_q + 8'd1;
                  end else begin
                     base_d = '0;
                     idx_d  = 8'd0;
                  end
                  prime_d = prime_dec;
                  gate_d  = (prime_dec == 8'd0);
               end else begin
                  gate_d = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // soft clear wins over stepping and over the CALC result
      if (!en_sync_q) begin
         base_d  = '0;
         idx_d   = 8'd0;
         prime_d = PRIME;
         gate_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         calc_cnt_q   <= 3'd0;
         acc_q        <= '0;
         fs_q         <= '0;
         n_q          <= 8'd0;
         pm_q         <= 2'b00;
         fno_q        <= 8'd0;
         max_q        <= '0;
         ready_q      <= 1'b0;
         base_q       <= '0;
         rd_max_q     <= '0;
         idx_q        <= 8'd0;
         prime_q      <= PRIME;
         gate_q       <= 1'b0;
         sync_out_q   <= 1'b0;
         base_valid_q <= 1'b0;
         vs_meta_q    <= 1'b0;
         vs_sync_q    <= 1'b0;
         vs_prev_q    <= 1'b0;
         en_meta_q    <= 1'b0;
         en_sync_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         calc_cnt_q   <= calc_cnt_d;
         acc_q        <= acc_d;
         fs_q         <= fs_d;
         n_q          <= n_d;
         pm_q         <= pm_d;
         fno_q        <= fno_d;
         max_q        <= max_d;
         ready_q      <= ready_d;
         base_q       <= base_d;
         rd_max_q     <= base_d + fs_d;
         idx_q        <= idx_d;
         prime_q      <= prime_d;
         gate_q       <= gate_d;
         // next-state gate so a soft clear silences SYNC_OUT without a lag cycle
         sync_out_q   <= vs_sync_q & gate_d;
         base_valid_q <= (base_q != '0) | en_sync_q;
         vs_meta_q    <= VSYNC;
         vs_sync_q    <= vs_meta_q;
         vs_prev_q    <= vs_sync_q;
         en_meta_q    <= SYNC_EN;
         en_sync_q    <= en_meta_q;
      end
   end

`ifdef FRAME_SCHED_MUTE_EN
   logic fv;
   logic blank_q;
   assign fv = ~vs_prev_q & vs_sync_q;
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)   blank_q <= 1'b0;
      else if (fv) blank_q <= ~en_sync_q;
   end
   assign BLANK = blank_q;
`else
   assign BLANK = 1'b0;
`endif

   assign BASE_ADDR   = base_q;
   assign RD_MAX_ADDR = rd_max_q;
   assign MAX_ADDR    = max_q;
   assign FRAME_IDX   = idx_q;
   assign READY       = ready_q;
   assign SYNC_OUT    = sync_out_q;
   assign BASE_VALID  = base_valid_q;

endmodule

// File: tb/tb_frame_base_scheduler.sv
// Bench for frame_base_scheduler: directed scenarios plus a randomized stretch
// of configuration changes and frames, all checked against a frame-level model.
module tb_frame_base_scheduler;

   localparam int FW    = 307200;
   localparam int AW    = 27;
   localparam int PRIME = 3;
`ifdef FRAME_SCHED_MUTE_EN
   localparam bit MUTE = 1'b1;
`else
   localparam bit MUTE = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RESET, VSYNC, SYNC_EN, ADVANCE;
   logic [1:0]    PIXEL_MODE;
   logic [7:0]    FRAME_NO;
   logic [AW-1:0] BASE_ADDR, RD_MAX_ADDR, MAX_ADDR;
   logic [7:0]    FRAME_IDX;
   logic          READY, SYNC_OUT, BASE_VALID, BLANK;

   frame_base_scheduler #(.FRAME_WORDS(FW), .ADDR_W(AW), .PRIME_FRAMES(PRIME)) dut (
      .CLK(CLK), .RESET(RESET), .VSYNC(VSYNC), .SYNC_EN(SYNC_EN), .ADVANCE(ADVANCE),
      .PIXEL_MODE(PIXEL_MODE), .FRAME_NO(FRAME_NO), .BASE_ADDR(BASE_ADDR),
      .RD_MAX_ADDR(RD_MAX_ADDR), .MAX_ADDR(MAX_ADDR), .FRAME_IDX(FRAME_IDX),
      .READY(READY), .SYNC_OUT(SYNC_OUT), .BASE_VALID(BASE_VALID), .BLANK(BLANK));

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   longint m_base, m_idx, m_fs, m_max;
   int     m_prime;
   bit     m_gate;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset();
      m_base  = 0;
      m_idx   = 0;
      m_prime = PRIME;
      m_gate  = 0;
   endtask

   task automatic model_cfg(input int pm, input int fno);
      longint n;
      m_fs  = (pm == 1) ? 38400 : FW;
      n     = (pm == 0 || fno == 0) ? 1 : fno;
      m_max = m_fs * n;
      if (m_base >= m_max) begin
         m_base = 0;
         m_idx  = 0;
      end
   endtask

   task automatic chk_pos(input string tag);
      chk({tag, "_base"},  BASE_ADDR, m_base);
      chk({tag, "_idx"},   FRAME_IDX, m_idx);
      chk({tag, "_rdmax"}, RD_MAX_ADDR, m_base + m_fs);
   endtask

   task automatic apply_cfg(input int pm, input int fno);
      bit changed;
      changed    = (PIXEL_MODE != 2'(pm)) || (FRAME_NO != 8'(fno));
      PIXEL_MODE = 2'(pm);
      FRAME_NO   = 8'(fno);
      tick();
      if (changed) chk("cfg_ready_low", READY, 0);
      repeat (11) tick();
      model_cfg(pm, fno);
      chk("cfg_max", MAX_ADDR, m_max);
      chk("cfg_ready", READY, 1);
      chk_pos("cfg");
   endtask

   task automatic frame(input bit adv);
      ADVANCE = adv;
      VSYNC   = 1'b0;
      repeat (6) tick();
      if (adv) begin
         if (m_base + m_fs < m_max) begin
            m_base += m_fs;
            m_idx  += 1;
         end else begin
            m_base = 0;
            m_idx  = 0;
         end
         if (m_prime > 0) m_prime--;
         m_gate = (m_prime == 0);
      end else begin
         m_gate = 0;
      end
      chk_pos("frm");
      chk("frm_syncout_lo", SYNC_OUT, 0);
      VSYNC = 1'b1;
      repeat (6) tick();
      chk("frm_syncout_hi", SYNC_OUT, m_gate);
      chk("frm_bvalid", BASE_VALID, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_base"},   BASE_ADDR, 0);
      chk({tag, "_rdmax"},  RD_MAX_ADDR, 0);
      chk({tag, "_max"},    MAX_ADDR, 0);
      chk({tag, "_idx"},    FRAME_IDX, 0);
      chk({tag, "_ready"},  READY, 0);
      chk({tag, "_sync"},   SYNC_OUT, 0);
      chk({tag, "_bvalid"}, BASE_VALID, 0);
      chk({tag, "_blank"},  BLANK, 0);
   endtask

   task automatic release_and_calc(input string tag);
      RESET = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 8) chk({tag, "_ready_e8"}, READY, 0);
         if (k == 9) chk({tag, "_ready_e9"}, READY, 1);
      end
   endtask

   longint exp_seq [5] = '{307200, 614400, 921600, 0, 307200};
   longint exp_idx [5] = '{1, 2, 3, 0, 1};

   initial begin
      RESET = 1'b1; VSYNC = 1'b1; SYNC_EN = 1'b1; ADVANCE = 1'b0;
      PIXEL_MODE = 2'b10; FRAME_NO = 8'd4;
      repeat (3) tick();
      check_reset_outputs("rst");

      // reset release: READY on the 9th edge, ring = 4 full frames
      release_and_calc("rel");
      model_reset();
      model_cfg(2, 4);
      chk("rel_max", MAX_ADDR, 1228800);
      chk_pos("rel");

      // five advancing frames, priming opens SYNC_OUT at the 3rd boundary
      for (int i = 0; i < 5; i++) begin
         frame(1'b1);
         chk("seq_base", BASE_ADDR, exp_seq[i]);
         chk("seq_idx", FRAME_IDX, exp_idx[i]);
      end

      // shrink ring while base sits beyond it
      frame(1'b1);
      frame(1'b1);
      chk("shrink_pre", BASE_ADDR, 921600);
      apply_cfg(2, 2);
      chk("shrink_base", BASE_ADDR, 0);
      chk("shrink_max", MAX_ADDR, 614400);

      // 1-bit mode, single frame: base wraps to 0 every frame
      apply_cfg(1, 0);
      chk("onebit_max", MAX_ADDR, 38400);
      frame(1'b1);
      frame(1'b1);
      chk("onebit_base", BASE_ADDR, 0);

      // randomized configuration changes and advance patterns
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            int pm, fno;
            pm  = $urandom_range(0, 3);
            fno = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 6) : $urandom_range(0, 255);
            apply_cfg(pm, fno);
         end
         frame($urandom_range(0, 3) != 0);
      end

      // soft clear while base = 614400
      apply_cfg(2, 4);
      for (int i = 0; i < 6 && m_base != 614400; i++) frame(1'b1);
      chk("clr_pre", BASE_ADDR, 614400);
      SYNC_EN = 1'b0;
      repeat (3) tick();
      chk("clr_base", BASE_ADDR, 0);
      chk("clr_idx", FRAME_IDX, 0);
      chk("clr_sync", SYNC_OUT, 0);
      repeat (2) tick();
      chk("clr_bvalid", BASE_VALID, 0);
      ADVANCE = 1'b1;
      VSYNC = 1'b0; repeat (6) tick();
      VSYNC = 1'b1; repeat (6) tick();
      chk("clr_base_hold", BASE_ADDR, 0);
      chk("clr_blank", BLANK, MUTE);
      model_reset();
      SYNC_EN = 1'b1;
      repeat (3) tick();
      frame(1'b1);
      chk("unclr_blank", BLANK, 0);

      // reset during the 4th CALC cycle
      FRAME_NO = 8'd3;
      repeat (4) tick();
      chk("midcalc_ready", READY, 0);
      RESET = 1'b1;
      #1;
      check_reset_outputs("midrst");
      tick();
      release_and_calc("rerun");
      model_reset();
      model_cfg(2, 3);
      chk("rerun_max", MAX_ADDR, 921600);
      frame(1'b1);
      chk("rerun_base", BASE_ADDR, 307200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
